// File: rtl/pc_gen_ras.sv
`default_nettype none
// ============================================================================
// pc_gen_ras : fetch PC register with fixed-priority redirect and optional RAS
// Optional feature macro: PC_GEN_RAS_EN (return-address stack)
// Revision: 1.0
// ============================================================================
module pc_gen_ras #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'hBFC0_0000),
  parameter int                INST_BYTES = 4,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_ready,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_adel,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              j_taken,
  input  logic [25:0]       jump_target,
  input  logic              jr_taken,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              call,
  input  logic              ret,
  input  logic              ex_signal,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_valid
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              pc_adel_q, pc_adel_d;
  logic              pc_load;

  always_comb begin
    pc_d       = pc_q;
    pc_load    = 1'b1;
    pc_valid_d = 1'b1;
    if (ex_signal) begin
      pc_d = ex_addr;
    end else if (jr_taken) begin
      pc_d = jr_target;
    end else if (j_taken) begin
      // J keeps the upper region of the current pc and fills 28 low bits
      pc_d = {pc_q[ADDR_W-1:28], jump_target, 2'b00};
    end else if (br_taken) begin
      pc_d = pc_q + branch_offset;
    end else if (pc_valid_q && fetch_ready) begin
      pc_d = pc_q + ADDR_W'(INST_BYTES);
    end else begin
      pc_load = 1'b0;
    end
    pc_adel_d = pc_load ? (pc_d[1:0] != 2'b00) : pc_adel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      pc_adel_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      pc_adel_q  <= pc_adel_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign pc_adel  = pc_adel_q;

`ifdef PC_GEN_RAS_EN
  localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(RAS_DEPTH);

  logic [ADDR_W-1:0]  ras_mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  ras_mem_d [RAS_DEPTH];
  logic [c_ptr_w-1:0] ras_ptr_q, ras_ptr_d;
  logic [c_cnt_w-1:0] ras_cnt_q, ras_cnt_d;
  logic               ras_push, ras_pop;
  logic [ADDR_W-1:0]  ras_ret_addr;

  // ras_ptr_q always points at the top entry; a power-of-two depth lets the
  // pointer wrap naturally so a push when full overwrites the oldest entry.
  always_comb begin
    ras_push     = (j_taken | jr_taken) & call;
    ras_pop      = jr_taken & ret;
    ras_ret_addr = pc_q + ADDR_W'(8);
    ras_mem_d    = ras_mem_q;
    ras_ptr_d    = ras_ptr_q;
    ras_cnt_d    = ras_cnt_q;
    if (ex_signal) begin
      ras_cnt_d = '0;
    end else if (ras_push && ras_pop) begin
      ras_mem_d[ras_ptr_q] = ras_ret_addr;
    end else if (ras_push) begin
      ras_ptr_d            = ras_ptr_q + 1'b1;
      ras_mem_d[ras_ptr_d] = ras_ret_addr;
      if (ras_cnt_q != c_full) begin
        ras_cnt_d = ras_cnt_q + 1'b1;
      end
    end else if (ras_pop && (ras_cnt_q != '0)) begin
      ras_ptr_d = ras_ptr_q - 1'b1;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ras_mem_q <= ras_mem_d;
  end

  assign ras_valid = (ras_cnt_q != '0);
  assign ras_top   = ras_valid ? ras_mem_q[ras_ptr_q] : '0;
`else
  logic unused_ras;
  assign unused_ras = &{1'b0, call, ret, RAS_DEPTH[0]};
  assign ras_top    = '0;
  assign ras_valid  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_ras.sv
`default_nettype none
// ============================================================================
// tb_pc_gen_ras : scoreboard bench for pc_gen_ras with queue-based RAS model
// Revision: 1.0
// ============================================================================
module tb_pc_gen_ras;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, fetch_ready, pc_valid, pc_adel;
  logic [31:0] pc, branch_offset, jr_target, ex_addr, ras_top;
  logic        br_taken, j_taken, jr_taken, call, ret, ex_signal, ras_valid;
  logic [25:0] jump_target;

  always #5 clk = ~clk;

  pc_gen_ras #(.ADDR_W(32), .RESET_PC(RST_PC), .INST_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .pc_valid(pc_valid), .pc(pc),
    .pc_adel(pc_adel), .br_taken(br_taken), .branch_offset(branch_offset),
    .j_taken(j_taken), .jump_target(jump_target), .jr_taken(jr_taken),
    .jr_target(jr_target), .call(call), .ret(ret), .ex_signal(ex_signal),
    .ex_addr(ex_addr), .ras_top(ras_top), .ras_valid(ras_valid)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    logic        valid;
    logic        adel;
    logic [31:0] top;
    logic        rv;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // reference state: RAS kept as an ordered list, newest at the back
  logic [31:0] m_pc = RST_PC;
  logic        m_valid = 1'b0;
  logic        m_adel = 1'b0;
  logic [31:0] m_ras[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic idle();
    br_taken = 0; j_taken = 0; jr_taken = 0; call = 0; ret = 0; ex_signal = 0;
    branch_offset = 0; jump_target = 0; jr_target = 0; ex_addr = 0;
  endtask

  // apply current inputs to the model, queue the expected post-edge state, clock once
  task automatic cycle();
    exp_t        e;
    logic [31:0] npc;
    logic        ld, psh, pp;
    if (reset) begin
      m_pc = RST_PC; m_valid = 0; m_adel = 0; m_ras.delete();
    end else begin
      psh = (j_taken | jr_taken) & call;
      pp  = jr_taken & ret;
      if (ex_signal) m_ras.delete();
      else if (psh && pp) begin
        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + 32'd8;
      end else if (psh) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd8);
      end else if (pp && m_ras.size() > 0) void'(m_ras.pop_back());
      ld = 1;
      if (ex_signal)                 npc = ex_addr;
      else if (jr_taken)             npc = jr_target;
      else if (j_taken)              npc = {m_pc[31:28], jump_target, 2'b00};
      else if (br_taken)             npc = m_pc + branch_offset;
      else if (m_valid && fetch_ready) npc = m_pc + 32'd4;
      else begin npc = m_pc; ld = 0; end
      if (ld) m_adel = (npc[1:0] != 2'b00);
      m_pc = npc; m_valid = 1;
    end
    e.cyc = cyc + 1; e.pc = m_pc; e.valid = m_valid; e.adel = m_adel;
    e.rv  = RAS_ON && (m_ras.size() > 0);
    e.top = e.rv ? m_ras[m_ras.size()-1] : 32'd0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        me = sb.pop_front();
        chk("sb_pc", pc, me.pc);
        chk("sb_valid", {31'd0, pc_valid}, {31'd0, me.valid});
        chk("sb_adel", {31'd0, pc_adel}, {31'd0, me.adel});
        chk("sb_ras_top", ras_top, me.top);
        chk("sb_ras_valid", {31'd0, ras_valid}, {31'd0, me.rv});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tops [4];
    logic [31:0] a;
    tops[0] = 32'hD8; tops[1] = 32'hC8; tops[2] = 32'hB8; tops[3] = 32'h0;
    idle(); reset = 1; fetch_ready = 1;
    cycle(); cycle();
    @(negedge clk);
    chk("reset_pc", pc, RST_PC);
    chk("reset_valid", {31'd0, pc_valid}, 32'd0);
    reset = 0;
    repeat (5) cycle();
    @(negedge clk);
    chk("seq_pc", pc, 32'hBFC0_0010);
    fetch_ready = 0;
    repeat (3) cycle();
    @(negedge clk);
    chk("stall_pc", pc, 32'hBFC0_0010);
    br_taken = 1; branch_offset = 32'h20; cycle(); idle();
    @(negedge clk);
    chk("br_stall_pc", pc, 32'hBFC0_0030);
    ex_signal = 1; ex_addr = 32'hBFC0_0380; jr_taken = 1; jr_target = 32'h8000_1000;
    j_taken = 1; jump_target = 26'h3FF_FFFF; cycle(); idle();
    @(negedge clk);
    chk("prio_pc", pc, 32'hBFC0_0380);
    chk("prio_adel", {31'd0, pc_adel}, 32'd0);
    jr_taken = 1; jr_target = 32'h8000_1002; cycle(); idle();
    @(negedge clk);
    chk("mis_adel", {31'd0, pc_adel}, 32'd1);
    fetch_ready = 1; cycle();
    @(negedge clk);
    chk("mis_seq_pc", pc, 32'h8000_1006);
    chk("mis_seq_adel", {31'd0, pc_adel}, 32'd1);
    j_taken = 1; jump_target = 26'h40; cycle(); idle();
    @(negedge clk);
    chk("j_pc", pc, 32'h8000_0100);
    chk("j_adel", {31'd0, pc_adel}, 32'd0);

    jr_taken = 1; jr_target = 32'hA0; cycle();
    for (int k = 0; k < 5; k++) begin
      jr_taken = 1; call = 1; jr_target = 32'hA0 + 32'(16 * (k + 1)); cycle();
    end
    idle();
    @(negedge clk);
    chk("ras_full_top", ras_top, RAS_ON ? 32'hE8 : 32'h0);
    for (int k = 0; k < 4; k++) begin
      jr_taken = 1; ret = 1; jr_target = 32'h300; cycle(); idle();
      @(negedge clk);
      chk("ras_pop_top", ras_top, RAS_ON ? tops[k] : 32'h0);
    end
    chk("ras_empty_valid", {31'd0, ras_valid}, 32'd0);
    jr_taken = 1; ret = 1; jr_target = 32'h300; cycle(); idle();
    @(negedge clk);
    chk("ras_underflow_valid", {31'd0, ras_valid}, 32'd0);

    jr_taken = 1; jr_target = 32'h80; cycle();
    call = 1; jr_target = 32'h90; cycle();
    jr_target = 32'h100; cycle();
    ret = 1; jr_target = 32'h200; cycle(); idle();
    @(negedge clk);
    chk("ras_pushpop_top", ras_top, RAS_ON ? 32'h108 : 32'h0);
    chk("ras_pushpop_valid", {31'd0, ras_valid}, RAS_ON ? 32'd1 : 32'd0);
    ex_signal = 1; ex_addr = 32'hBFC0_0380; cycle(); idle();
    @(negedge clk);
    chk("ras_ex_clear", {31'd0, ras_valid}, 32'd0);

    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      ex_signal   = ($urandom_range(0, 15) == 0);
      jr_taken    = ($urandom_range(0, 5) == 0);
      j_taken     = ($urandom_range(0, 5) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      call        = ($urandom_range(0, 2) == 0);
      ret         = ($urandom_range(0, 2) == 0);
      jump_target = 26'($urandom);
      a = $urandom; if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      ex_addr = a;
      a = $urandom; if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC;
      jr_target = a;
      a = $urandom_range(0, 255); if ($urandom_range(0, 1) == 0) a = -a;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      branch_offset = a;
      cycle();
    end
    idle(); reset = 0; cycle();
    @(negedge clk); #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
